// File: rtl/sfu_pkg.sv
// sfu_pkg: shared constants and types for the vector special-function unit.
//   SFU_MODE_LINEAR / SFU_MODE_RELU : post-processing mode encodings
//   SFU_SHIFT_BW                    : width of the requantizing shift amount
//   sfu_state_e                     : burst FSM state
package sfu_pkg;
  localparam logic SFU_MODE_LINEAR = 1'b0;
  localparam logic SFU_MODE_RELU   = 1'b1;
  localparam int   SFU_SHIFT_BW    = 4;

  typedef enum logic {
    SFU_IDLE  = 1'b0,   // accumulators zero, no beat held
    SFU_ACCUM = 1'b1    // at least one non-last beat accumulated
  } sfu_state_e;
endpackage

// File: rtl/sfu_lane.sv
// sfu_lane: one channel of the SFU. Accumulates signed psums, and on the last
// beat of a burst produces the shifted, optionally ReLU'd, narrowed result.
// Build option SFU_SAT_EN: clip out-of-range results instead of wrapping.
//   clk, rstn : clock, synchronous active-low reset
//   beat      : a beat is accepted this cycle
//   last      : accepted beat closes the burst
//   psum      : signed partial sum for this lane
//   mode      : SFU_MODE_LINEAR / SFU_MODE_RELU (used on last beat)
//   shift     : arithmetic right shift (used on last beat)
//   res       : narrowed result (valid when beat && last)
//   sat       : result was outside psum_bw range
module sfu_lane
  import sfu_pkg::*;
#(
  parameter int psum_bw = 16,
  parameter int acc_bw  = 24
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        beat,
  input  logic                        last,
  input  logic signed [psum_bw-1:0]   psum,
  input  logic                        mode,
  input  logic [SFU_SHIFT_BW-1:0]     shift,
  output logic [psum_bw-1:0]          res,
  output logic                        sat
);
  // Largest positive psum_bw value at acc_bw; the most negative is its complement.
  localparam logic signed [acc_bw-1:0] MAX_V =
    {{(acc_bw-psum_bw+1){1'b0}}, {(psum_bw-1){1'b1}}};
  localparam logic signed [acc_bw-1:0] MIN_V = ~MAX_V;

  logic signed [acc_bw-1:0] acc_q, acc_d;
  logic signed [acc_bw-1:0] fin;
  logic signed [acc_bw-1:0] r;

  always_comb begin
    fin   = acc_q + acc_bw'(psum);   // sign-extending add, wraps at acc_bw
    acc_d = acc_q;
    if (beat) acc_d = last ? '0 : fin;

    r = fin >>> shift;
    if (mode == SFU_MODE_RELU && r[acc_bw-1]) r = '0;

    sat = (r > MAX_V) || (r < MIN_V);
`ifdef SFU_SAT_EN
    if (r > MAX_V)      res = MAX_V[psum_bw-1:0];
    else if (r < MIN_V) res = MIN_V[psum_bw-1:0];
    else                res = r[psum_bw-1:0];
`else
    res = r[psum_bw-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) acc_q <= '0;
    else       acc_q <= acc_d;
  end
endmodule

// File: rtl/sfu_vec.sv
// sfu_vec: multi-lane special-function unit. Accumulates col signed psum lanes
// over a framed burst, requantizes on the last beat and emits one registered
// result vector per burst over valid/ready.
// Build option SFU_SAT_EN: saturate lanes to psum_bw range (else wrap).
//   clk, rstn            : clock, synchronous active-low reset
//   in_valid/in_ready    : input beat handshake, in_last marks burst end
//   psum_in              : col lanes of psum_bw, lane c at [c*psum_bw +: psum_bw]
//   mode, shift          : post-processing, sampled on the last beat
//   out_valid/out_ready  : result handshake
//   psum_out, out_sat    : result vector and any-lane-clipped flag
module sfu_vec
  import sfu_pkg::*;
#(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int acc_bw  = 24
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [col*psum_bw-1:0]    psum_in,
  input  logic                      mode,
  input  logic [SFU_SHIFT_BW-1:0]   shift,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [col*psum_bw-1:0]    psum_out,
  output logic                      out_sat
);
  sfu_state_e                    state_q, state_d;
  logic                          out_valid_q, out_valid_d;
  logic [col*psum_bw-1:0]        psum_out_q, psum_out_d;
  logic                          out_sat_q, out_sat_d;

  logic [col-1:0][psum_bw-1:0]   lane_res;
  logic [col-1:0]                lane_sat;
  logic                          beat;

  // A stalled result blocks input so accumulators never run ahead of it.
  assign in_ready = !out_valid_q || out_ready;
  assign beat     = in_valid && in_ready;

  for (genvar g = 0; g < col; g++) begin : g_lane
    sfu_lane #(.psum_bw(psum_bw), .acc_bw(acc_bw)) u_lane (
      .clk   (clk),
      .rstn  (rstn),
      .beat  (beat),
      .last  (in_last),
      .psum  (psum_in[g*psum_bw +: psum_bw]),
      .mode  (mode),
      .shift (shift),
      .res   (lane_res[g]),
      .sat   (lane_sat[g])
    );
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    psum_out_d  = psum_out_q;
    out_sat_d   = out_sat_q;
    if (beat) state_d = in_last ? SFU_IDLE : SFU_ACCUM;
    // A new result takes priority over draining, so load+drain has no bubble.
    if (beat && in_last) begin
      out_valid_d = 1'b1;
      psum_out_d  = lane_res;
      out_sat_d   = |lane_sat;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      psum_out_d  = '0;
      out_sat_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= SFU_IDLE;
      out_valid_q <= 1'b0;
      psum_out_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      psum_out_q  <= psum_out_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign psum_out  = psum_out_q;
  assign out_sat   = out_sat_q;
endmodule

// File: tb/tb_sfu_vec.sv
// tb_sfu_vec: directed plus randomized bench for sfu_vec (psum_bw=16, col=4).
// A burst-level reference model (per-lane integer sums, result register)
// predicts every output each cycle.
module tb_sfu_vec;
  localparam int PB = 16;
  localparam int NC = 4;
  localparam int AB = 24;

  logic              clk;
  logic              rstn;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [NC*PB-1:0]  psum_in;
  logic              mode;
  logic [3:0]        shift;
  logic              out_valid;
  logic              out_ready;
  logic [NC*PB-1:0]  psum_out;
  logic              out_sat;

  int total = 0;
  int bad   = 0;

  // reference model state
  longint            msum [NC];
  logic              m_valid;
  logic [NC*PB-1:0]  m_out;
  logic              m_sat;

  sfu_vec #(.psum_bw(PB), .col(NC), .acc_bw(AB)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .psum_in   (psum_in),
    .mode      (mode),
    .shift     (shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .psum_out  (psum_out),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [NC*PB-1:0] rep(input logic [15:0] v);
    return {v, v, v, v};
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < NC; c++) msum[c] = 0;
    m_valid = 1'b0;
    m_out   = '0;
    m_sat   = 1'b0;
  endfunction

  // One clock with the currently driven inputs; called and returns at negedge.
  task automatic cycle();
    logic             acc;
    logic             nsat;
    logic [NC*PB-1:0] nout;
    longint           r;
    logic signed [AB-1:0]  w;
    logic signed [PB-1:0]  p;
    acc = in_valid && (!m_valid || out_ready);
    #1;
    chk("in_ready", in_ready, !m_valid || out_ready);
    if (acc) begin
      for (int c = 0; c < NC; c++) begin
        p = psum_in[c*PB +: PB];
        msum[c] = msum[c] + p;
      end
      if (in_last) begin
        nsat = 1'b0;
        nout = '0;
        for (int c = 0; c < NC; c++) begin
          w = msum[c][AB-1:0];          // accumulator wraps at AB bits
          r = w;
          r = r >>> shift;
          if (mode && r < 0) r = 0;
          if (r > 32767 || r < -32768) nsat = 1'b1;
`ifdef SFU_SAT_EN
          if (r > 32767)  r = 32767;
          if (r < -32768) r = -32768;
`endif
          nout[c*PB +: PB] = r[15:0];
          msum[c] = 0;
        end
        m_valid = 1'b1;
        m_out   = nout;
        m_sat   = nsat;
      end else if (m_valid && out_ready) begin
        model_clear_out();
      end
    end else if (m_valid && out_ready) begin
      model_clear_out();
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", out_valid, m_valid);
    chk("psum_out", psum_out, m_out);
    chk("out_sat", out_sat, m_sat);
  endtask

  function automatic void model_clear_out();
    m_valid = 1'b0;
    m_out   = '0;
    m_sat   = 1'b0;
  endfunction

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [NC*PB-1:0] d, input logic last,
                      input logic md, input logic [3:0] sh);
    logic acc_now;
    logic done;
    in_valid = 1'b1;
    in_last  = last;
    psum_in  = d;
    mode     = md;
    shift    = sh;
    done     = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      acc_now = !m_valid || out_ready;
      cycle();
      if (acc_now) done = 1'b1;
      else out_ready = 1'b1;
    end
    if (!done) chk("send_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_clear();
  endtask

  initial begin
    logic [NC*PB-1:0] d;
    int v;
    rstn = 1'b0; in_valid = 1'b0; in_last = 1'b0; psum_in = '0;
    mode = 1'b0; shift = '0; out_ready = 1'b0;
    model_clear();
    @(negedge clk);
    do_reset();

    // reset state
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_psum", psum_out, '0);
    chk("rst_sat", out_sat, 1'b0);
    #1 chk("rst_ready", in_ready, 1'b1);

    // 3-beat burst of +5, ReLU, no shift
    out_ready = 1'b1;
    send(rep(16'd5), 1'b0, 1'b1, 4'd0);
    send(rep(16'd5), 1'b0, 1'b1, 4'd0);
    chk("b3_pre", out_valid, 1'b0);
    send(rep(16'd5), 1'b1, 1'b1, 4'd0);
    chk("b3_valid", out_valid, 1'b1);
    chk("b3_val", psum_out, rep(16'd15));

    // ReLU vs linear: -7 + 2
    send(rep(16'hFFF9), 1'b0, 1'b1, 4'd0);
    send(rep(16'd2), 1'b1, 1'b1, 4'd0);
    chk("relu", psum_out, rep(16'd0));
    send(rep(16'hFFF9), 1'b0, 1'b0, 4'd0);
    send(rep(16'd2), 1'b1, 1'b0, 4'd0);
    chk("linear", psum_out, rep(16'hFFFB));

    // shift
    send(rep(16'd40), 1'b1, 1'b0, 4'd3);
    chk("shr_pos", psum_out, rep(16'd5));
    send(rep(16'hFFD8), 1'b1, 1'b0, 4'd3);
    chk("shr_neg", psum_out, rep(16'hFFFB));

    // saturation in lane 0
    for (int i = 0; i < 4; i++)
      send({48'h0, 16'h7000}, (i == 3), 1'b0, 4'd0);
`ifdef SFU_SAT_EN
    chk("sat_lane0", psum_out[15:0], 16'h7FFF);
`else
    chk("sat_lane0", psum_out[15:0], 16'hC000);
`endif
    chk("sat_flag", out_sat, 1'b1);
    chk("sat_others", psum_out[63:16], 48'h0);

    // back-pressure: hold result, block input, then load+drain together
    idle(1);
    out_ready = 1'b0;
    send(rep(16'd3), 1'b1, 1'b0, 4'd0);
    in_valid = 1'b1; in_last = 1'b1; psum_in = rep(16'd4); mode = 1'b0; shift = '0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_ready", in_ready, 1'b0);
      chk("bp_hold", psum_out, rep(16'd3));
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_valid", out_valid, 1'b1);
    chk("bp_new", psum_out, rep(16'd4));
    in_valid = 1'b0; in_last = 1'b0;

    // back-to-back single-beat bursts, no bubble
    for (int i = 1; i <= 3; i++) begin
      send(rep(16'(i * 11)), 1'b1, 1'b0, 4'd0);
      chk("b2b_valid", out_valid, 1'b1);
      chk("b2b_val", psum_out, rep(16'(i * 11)));
    end

    // reset mid-burst discards accumulators
    send(rep(16'd9), 1'b0, 1'b0, 4'd0);
    send(rep(16'd9), 1'b0, 1'b0, 4'd0);
    do_reset();
    chk("mrst_valid", out_valid, 1'b0);
    send(rep(16'd1), 1'b1, 1'b0, 4'd0);
    chk("mrst_val", psum_out, rep(16'd1));

    // randomized traffic
    for (int it = 0; it < 400; it++) begin
      out_ready = ($urandom_range(2) != 0);
      if ($urandom_range(4) == 0) begin
        idle(1);
      end else begin
        for (int c = 0; c < NC; c++) begin
          if ($urandom_range(7) == 0) v = $urandom_range(65535);
          else                        v = $urandom_range(6000) - 3000;
          d[c*PB +: PB] = v[15:0];
        end
        send(d, ($urandom_range(3) == 0), 1'($urandom_range(1)), 4'($urandom_range(15)));
      end
    end
    out_ready = 1'b1;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
